// File: rtl/knn_pkg.sv
// Shared types for the k-nearest-neighbour top-K selector and voter.
// The entry/list types are fixed-width here; the top checks its width parameters against them.
package knn_pkg;

   localparam int SUM_W = 10;
   localparam int LBL_W = 10;

   typedef logic [SUM_W-1:0] sum_t;
   typedef logic [LBL_W-1:0] lbl_t;

   typedef struct packed {
      logic valid;
      sum_t sum;
      lbl_t lbl;
   } topk_entry_t;

   typedef enum logic [1:0] {IDLE, SCAN, VOTE, FIN} state_t;

   localparam sum_t SUM_MAX = '1;

   localparam topk_entry_t EMPTY_ENTRY = '{valid: 1'b0, sum: SUM_MAX, lbl: '0};

endpackage

// File: rtl/knn_topk_ins.sv
// One-step sorted insertion into an ascending top-K list; combinational only.
// Ties keep the incumbent ahead, so earlier candidates win on equal sums.
module knn_topk_ins
   import knn_pkg::*;
#(
   parameter int K = 3
) (
   input  topk_entry_t [K-1:0] list_i,
   input  topk_entry_t         cand_i,
   output topk_entry_t [K-1:0] list_o
);

   // ins[i]: candidate belongs at or above slot i; monotone because valid entries are a sorted prefix
   logic [K-1:0] ins;

   genvar i;
   generate
      for (i = 0; i < K; i++) begin : g_slot
         assign ins[i] = !list_i[i].valid || (cand_i.sum < list_i[i].sum);
         if (i == 0) begin : g_head
            assign list_o[i] = ins[i] ? cand_i : list_i[i];
         end else begin : g_tail
            assign list_o[i] = !ins[i]    ? list_i[i]   :
                               ins[i-1]   ? list_i[i-1] : cand_i;
         end
      end
   endgenerate

endmodule

// File: rtl/knn_topk_vote.sv
// Captures distance sums and labels, keeps the K smallest via serial insertion,
// then majority-votes over their labels and reports label, vote count and nearest sum.
module knn_topk_vote
   import knn_pkg::*;
#(
   parameter int SUM_LEN  = 10,
   parameter int LBL_LEN  = 10,
   parameter int VECT_NUM = 6,
   parameter int K        = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [SUM_LEN-1:0]       inS [VECT_NUM],
   input  logic [LBL_LEN-1:0]       inL [VECT_NUM],
   output logic                     busy,
   output logic                     done,
   output logic [LBL_LEN-1:0]       outL,
   output logic [$clog2(K+1)-1:0]   outCnt,
   output logic [SUM_LEN-1:0]       outS
);

   localparam int IDX_W = (VECT_NUM > 1) ? $clog2(VECT_NUM) : 1;
   localparam int J_W   = (K > 1) ? $clog2(K) : 1;
   localparam int CNT_W = $clog2(K+1);

   generate
      if (K < 1 || K > VECT_NUM) begin : g_bad_k
         $error("knn_topk_vote: K must be in 1..VECT_NUM");
      end
      if (SUM_LEN != SUM_W || LBL_LEN != LBL_W) begin : g_bad_w
         $error("knn_topk_vote: SUM_LEN/LBL_LEN must match knn_pkg widths");
      end
   endgenerate

   state_t                 state_q;
   logic [IDX_W-1:0]       idx_q;
   logic [J_W-1:0]         j_q;
   sum_t                   shS_q [VECT_NUM];
   lbl_t                   shL_q [VECT_NUM];
   topk_entry_t [K-1:0]    list_q, list_d;
   topk_entry_t            cand;
   lbl_t                   best_lbl_q;
   logic [CNT_W-1:0]       best_cnt_q, cnt_j;

   logic                   busy_q, done_q;
   lbl_t                   outL_q;
   logic [CNT_W-1:0]       outCnt_q;
   sum_t                   outS_q;

   assign busy   = busy_q;
   assign done   = done_q;
   assign outL   = outL_q;
   assign outCnt = outCnt_q;
   assign outS   = outS_q;

   always_comb begin
      cand       = EMPTY_ENTRY;
      cand.valid = 1'b1;
      cand.sum   = shS_q[idx_q];
      cand.lbl   = shL_q[idx_q];
   end

   knn_topk_ins #(.K(K)) u_ins (
      .list_i (list_q),
      .cand_i (cand),
      .list_o (list_d)
   );

   // Votes for list[j]'s label across the whole list
   always_comb begin
      cnt_j = '0;
      for (int i = 0; i < K; i++) begin
         if (list_q[i].valid && (list_q[i].lbl == list_q[j_q].lbl))
            cnt_j = cnt_j + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         j_q        <= '0;
         best_lbl_q <= '0;
         best_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         outL_q     <= '0;
         outCnt_q   <= '0;
         outS_q     <= '0;
         for (int i = 0; i < VECT_NUM; i++) begin
            shS_q[i] <= '0;
            shL_q[i] <= '0;
         end
         for (int i = 0; i < K; i++) list_q[i] <= EMPTY_ENTRY;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < VECT_NUM; i++) begin
                     shS_q[i] <= inS[i];
                     shL_q[i] <= inL[i];
                  end
                  for (int i = 0; i < K; i++) list_q[i] <= EMPTY_ENTRY;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               list_q <= list_d;
               if (idx_q == IDX_W'(VECT_NUM-1)) begin
                  j_q        <= '0;
                  best_cnt_q <= '0;
                  best_lbl_q <= '0;
                  state_q    <= VOTE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            VOTE: begin
               // Strict compare: on a tie the nearer entry already holds best
               if (cnt_j > best_cnt_q) begin
                  best_cnt_q <= cnt_j;
                  best_lbl_q <= list_q[j_q].lbl;
               end
               if (j_q == J_W'(K-1)) state_q <= FIN;
               else                  j_q     <= j_q + J_W'(1);
            end
            FIN: begin
               outL_q   <= best_lbl_q;
               outCnt_q <= best_cnt_q;
               outS_q   <= list_q[0].sum;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_topk_vote.sv
// Directed bench for knn_topk_vote: table of vectors plus re-start and mid-run reset sequences.
module tb_knn_topk_vote;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [9:0] inS [6];
   logic [9:0] inL [6];
   logic       busy, done;
   logic [9:0] outL;
   logic [1:0] outCnt;
   logic [9:0] outS;

   int tests = 0;
   int fails = 0;

   knn_topk_vote #(.SUM_LEN(10), .LBL_LEN(10), .VECT_NUM(6), .K(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inS(inS), .inL(inL),
      .busy(busy), .done(done), .outL(outL), .outCnt(outCnt), .outS(outS)
   );

   always #5 clk = ~clk;

   typedef struct {
      string nm;
      int    s [6];
      int    l [6];
      int    eL;
      int    eC;
      int    eS;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int i = 0; i < 6; i++) begin
         inS[i] = 10'(v.s[i]);
         inL[i] = 10'(v.l[i]);
      end
   endtask

   task automatic scramble();
      for (int i = 0; i < 6; i++) begin
         inS[i] = 10'd0;
         inL[i] = 10'd9;
      end
   endtask

   // Pulses start so that edge T samples it; returns just after edge T with start low
   task automatic start_run(input vec_t v);
      @(negedge clk);
      load(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      check({v.nm, " busy after start"}, 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      scramble();
   endtask

   // Counts edges after T until done; optionally holds start high across the FIN edge
   task automatic wait_done(input int n0, input bit fin_poke, output int lat);
      int n;
      n = n0;
      lat = -1;
      while (lat < 0 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (done) lat = n;
         else if (fin_poke && n == 9) start = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic check_result(input vec_t v, input int lat);
      check({v.nm, " latency"}, 32'(lat), 32'd10);
      check({v.nm, " busy at done"}, 32'(busy), 32'd0);
      check({v.nm, " outL"}, 32'(outL), 32'(v.eL));
      check({v.nm, " outCnt"}, 32'(outCnt), 32'(v.eC));
      check({v.nm, " outS"}, 32'(outS), 32'(v.eS));
      @(posedge clk);
      #1;
      check({v.nm, " done one cycle"}, 32'(done), 32'd0);
      check({v.nm, " outL hold"}, 32'(outL), 32'(v.eL));
   endtask

   task automatic expect_quiet(input string nm, input int cycles);
      int dn;
      dn = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         if (done || busy) dn++;
      end
      check({nm, " no done/busy"}, 32'(dn), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vecs[0] = '{"s1_majority", '{50,10,40,20,60,30},       '{1,2,1,2,3,2}, 2, 3, 10};
      vecs[1] = '{"s2_tie_near", '{5,9,7,30,40,50},          '{4,5,6,7,8,9}, 4, 1, 5};
      vecs[2] = '{"s3_eq_sums",  '{15,15,15,15,15,15},       '{7,8,9,1,2,3}, 7, 1, 15};
      vecs[3] = '{"s4_max_sums", '{1023,1023,1023,1023,1023,1023}, '{3,3,1,1,1,2}, 3, 2, 1023};
      vecs[4] = '{"s5_later_win",'{1,2,3,100,200,300},       '{5,6,6,5,5,5}, 6, 2, 1};

      scramble();
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset outL", 32'(outL), 32'd0);
      check("reset outCnt", 32'(outCnt), 32'd0);
      check("reset outS", 32'(outS), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         start_run(vecs[v]);
         wait_done(0, 1'b0, lat);
         check_result(vecs[v], lat);
      end

      // Re-pulse start at T+4 with other data, and again across the FIN edge
      start_run(vecs[0]);
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, 1'b1, lat);
      check_result(vecs[0], lat);
      expect_quiet("after restart pokes", 15);

      // Mid-SCAN reset: abort, outputs cleared, then a clean run
      start_run(vecs[0]);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst outL", 32'(outL), 32'd0);
      check("midrst outCnt", 32'(outCnt), 32'd0);
      check("midrst outS", 32'(outS), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      expect_quiet("after midrst", 15);
      start_run(vecs[0]);
      wait_done(0, 1'b0, lat);
      check_result(vecs[0], lat);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
